// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and helpers for the byte-serial load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp,
    StErr
  } lsu_state_e;

  // Reserved size yields zero bytes; callers reject it before use.
  function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] acc, input logic [1:0] size,
                                              input logic is_unsigned);
    case (size)
      SZ_BYTE: return is_unsigned ? {24'h0, acc[7:0]} : {{24{acc[7]}}, acc[7:0]};
      SZ_HALF: return is_unsigned ? {16'h0, acc[15:0]} : {{16{acc[15]}}, acc[15:0]};
      default: return acc;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Final load-result selection: picks the valid low bytes of the accumulator and extends them.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  always_comb begin
    value = extend_load(acc, size, is_unsigned);
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits a byte/half/word load or store into big-endian single-byte memory transactions.
module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        size_q;
  logic              store_q;
  logic              unsigned_q;
  logic [31:0]       wdata_q;
  logic [31:0]       acc_q;
  logic [31:0]       rdata_q;

  logic        legal;
  logic        accept;
  logic        beat;
  logic [1:0]  req_last;
  logic [1:0]  cur_last;
  logic [1:0]  offset;
  logic [31:0] acc_next;
  logic [31:0] ext_value;

  always_comb begin
    case (size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = ~addr[0];
      SZ_WORD: legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign accept   = (state_q == StIdle) && start && legal;
  assign beat     = (state_q == StAccess) && mem_ack;
  assign req_last = 2'(bytes_for_size(size) - 3'd1);
  assign cur_last = 2'(bytes_for_size(size_q) - 3'd1);
  assign offset   = cur_last - cnt_q;
  assign acc_next = {acc_q[23:0], mem_rdata};

  // Extension runs on the post-shift accumulator so rdata is already valid in the RESP cycle.
  lsu_load_extend u_load_extend (
    .acc         (acc_next),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .value       (ext_value)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = legal ? StAccess : StErr;
      end
      StAccess: begin
        if (mem_ack && (cnt_q == 2'd0)) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q      <= 2'd0;
      base_q     <= '0;
      size_q     <= SZ_BYTE;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'h0;
      acc_q      <= 32'h0;
      rdata_q    <= 32'h0;
    end else if (accept) begin
      cnt_q      <= req_last;
      base_q     <= addr;
      size_q     <= size;
      store_q    <= is_store;
      unsigned_q <= is_unsigned;
      wdata_q    <= wdata;
    end else if (beat) begin
      if (!store_q) acc_q <= acc_next;
      if (cnt_q != 2'd0) begin
        cnt_q <= cnt_q - 2'd1;
      end else if (!store_q) begin
        rdata_q <= ext_value;
      end
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StResp) || (state_q == StErr);
    err     = (state_q == StErr);
    mem_req = (state_q == StAccess);
    mem_we  = (state_q == StAccess) && store_q;
  end

  // Counter value equals the number of bytes still to follow, so it indexes the MSB-first byte.
  assign mem_addr  = base_q + {{(ADDR_W - 2){1'b0}}, offset};
  assign mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Scoreboard bench: expected byte transactions are queued at request time and checked on ack.
module tb_lsu_byte_sequencer;

  localparam int unsigned AW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          is_store;
  logic [1:0]    size;
  logic          is_unsigned;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [7:0]  d;
  } txn_t;

  txn_t        exp_q[$];
  logic [7:0]  mem [0:255];
  logic [31:0] stall_addr;
  int          stall_left;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr[7:0]];

  lsu_byte_sequencer #(.ADDR_W(AW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .is_store    (is_store),
    .size        (size),
    .is_unsigned (is_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  // Issues one request, plays the byte RAM, and returns the cycle of the done pulse.
  task automatic do_access(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int done_cyc, output logic err_o, output logic [31:0] rd_o);
    int   n;
    int   cyc;
    logic fin;
    logic ok;
    txn_t t;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    ok = (sz == 2'b00) || (sz == 2'b01 && a[0] == 1'b0) || (sz == 2'b10 && a[1:0] == 2'b00);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        t.a  = a + i;
        t.we = st;
        t.d  = st ? 8'((wd >> (8 * (n - 1 - i))) & 32'hFF) : 8'h00;
        exp_q.push_back(t);
      end
    end
    @(negedge CLK);
    start = 1'b1; is_store = st; size = sz; is_unsigned = uns; addr = a; wdata = wd;
    mem_ack = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1; fin = 1'b0; done_cyc = -1; err_o = 1'bx; rd_o = 32'hx;
    while (!fin && cyc < 50) begin
      if (mem_req && mem_addr == stall_addr && stall_left > 0) begin
        mem_ack = 1'b0;
        stall_left--;
      end else begin
        mem_ack = 1'b1;
      end
      if (mem_req && mem_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txn_extra: got addr=%h we=%b with none expected", mem_addr, mem_we);
        end else begin
          t = exp_q.pop_front();
          if ({mem_addr, mem_we, (mem_we ? mem_wdata : 8'h00)} !== {t.a, t.we, t.d}) begin
            errors++;
            $display("FAIL txn: got addr=%h we=%b d=%h, want addr=%h we=%b d=%h",
                     mem_addr, mem_we, mem_wdata, t.a, t.we, t.d);
          end
        end
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
      end
      if (done) begin
        fin = 1'b1; done_cyc = cyc; err_o = err; rd_o = rdata;
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end
    mem_ack = 1'b1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL txn_missing: %0d expected transactions never seen", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #12;
    checks++;
    if ({busy, done, err, mem_req, mem_we, rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b err=%b req=%b we=%b rdata=%h addr=%h wd=%h want all 0",
               busy, done, err, mem_req, mem_we, rdata, mem_addr, mem_wdata);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_word_store();
    int c; logic e; logic [31:0] r;
    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, c, e, r);
    checks++;
    if (c !== 5 || e !== 1'b0 || r !== 32'h0) begin
      errors++;
      $display("FAIL word_store: cyc=%0d err=%b rdata=%h want 5 0 00000000", c, e, r);
    end
  endtask

  task automatic test_word_load_stall();
    int c; logic e; logic [31:0] r;
    stall_addr = 32'h12; stall_left = 2;
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, c, e, r);
    checks++;
    if (c !== 7 || e !== 1'b0 || r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_load_stall: cyc=%0d err=%b rdata=%h want 7 0 deadbeef", c, e, r);
    end
  endtask

  task automatic test_byte_half();
    int c; logic e; logic [31:0] r;
    do_access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, c, e, r);
    checks++;
    if (c !== 2 || e !== 1'b0 || r !== 32'hFFFFFFAD) begin
      errors++;
      $display("FAIL byte_signed: cyc=%0d err=%b rdata=%h want 2 0 ffffffad", c, e, r);
    end
    do_access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, c, e, r);
    checks++;
    if (c !== 2 || r !== 32'h000000AD) begin
      errors++;
      $display("FAIL byte_unsigned: cyc=%0d rdata=%h want 2 000000ad", c, r);
    end
    do_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, c, e, r);
    checks++;
    if (c !== 3 || e !== 1'b0 || r !== 32'hFFFFBEEF) begin
      errors++;
      $display("FAIL half_signed: cyc=%0d err=%b rdata=%h want 3 0 ffffbeef", c, e, r);
    end
    do_access(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, c, e, r);
    checks++;
    if (c !== 2 || e !== 1'b0 || r !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL byte_top_addr: cyc=%0d err=%b rdata=%h want 2 0 ffffff80", c, e, r);
    end
    do_access(1'b1, 2'b01, 1'b0, 32'h20, 32'h1234ABCD, c, e, r);
    checks++;
    if (c !== 3 || e !== 1'b0 || r !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL half_store: cyc=%0d err=%b rdata=%h want 3 0 ffffff80", c, e, r);
    end
  endtask

  task automatic test_errors();
    int c; logic e; logic [31:0] r;
    logic [1:0]  szs [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ads [3] = '{32'h13, 32'h12, 32'h10};
    for (int i = 0; i < 3; i++) begin
      do_access(1'b1, szs[i], 1'b0, ads[i], 32'h5555AAAA, c, e, r);
      checks++;
      if (c !== 1 || e !== 1'b1 || r !== 32'hFFFFFF80) begin
        errors++;
        $display("FAIL err_case%0d: cyc=%0d err=%b rdata=%h want 1 1 ffffff80", i, c, e, r);
      end
    end
  endtask

  task automatic test_reset_abort();
    int c; int dones; logic e; logic [31:0] r;
    @(negedge CLK);
    start = 1'b1; is_store = 1'b0; size = 2'b10; is_unsigned = 1'b0; addr = 32'h10;
    mem_ack = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, done, rdata} !== '0) begin
      errors++;
      $display("FAIL abort_reset: req=%b busy=%b done=%b rdata=%h want 0 0 0 0",
               mem_req, busy, done, rdata);
    end
    @(negedge CLK);
    RST = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
    end
    do_access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, c, e, r);
    checks++;
    if (c !== 2 || e !== 1'b0 || r !== 32'h000000AD) begin
      errors++;
      $display("FAIL abort_recover: cyc=%0d err=%b rdata=%h want 2 0 000000ad", c, e, r);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int cyc;
    @(negedge CLK);
    start = 1'b1; is_store = 1'b0; size = 2'b10; is_unsigned = 1'b0; addr = 32'h10;
    mem_ack = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    start = 1'b1; size = 2'b01; addr = 32'h20;
    @(negedge CLK);
    start = 1'b0;
    mem_ack = 1'b1;
    dones = 0; cyc = 0;
    while (dones == 0 && cyc < 30) begin
      @(negedge CLK);
      cyc++;
      if (done) begin
        dones++;
        start = 1'b1; size = 2'b00; addr = 32'h11;
      end
    end
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if (dones != 1 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL busy_start: dones=%0d rdata=%h want 1 deadbeef", dones, rdata);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (done) dones++;
    end
    checks++;
    if (dones != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL resp_start: dones=%0d busy=%b want 1 0", dones, busy);
    end
  endtask

  initial begin
    start = 1'b0; is_store = 1'b0; size = 2'b00; is_unsigned = 1'b0;
    addr = '0; wdata = 32'h0; mem_ack = 1'b1;
    stall_addr = 32'hFFFF_0000; stall_left = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[255] = 8'h80;
    test_reset();
    test_word_store();
    test_word_load_stall();
    test_byte_half();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Load/store initiator between the CPU datapath and a byte-wide data RAM port.
- Turns one word, halfword or byte load/store request into a sequence of single-byte memory transactions, most significant byte first (big-endian: the byte at `addr` is bits 31:24).
- Assembles load data and sign- or zero-extends it. Raises `done` when the access completes.
- Sits in the MEM stage of the multi-cycle CPU variant; the existing byte RAM is the responder.

Parameters:
- `ADDR_W`, 32, width of CPU and memory byte addresses.

Ports:
- `CLK`  input  1  system clock; all state updates on rising edge.
- `RST`  input  1  asynchronous, active-low reset.
- `start`  input  1  request strobe; sampled only in IDLE.
- `is_store`  input  1  1 = store, 0 = load.
- `size`  input  2  00 byte, 01 half, 10 word, 11 reserved.
- `is_unsigned`  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
- `addr`  input  ADDR_W  byte address of the access.
- `wdata`  input  32  store data; the low `size` bytes are used.
- `busy`  output  1  high from the cycle after an accepted start until `done`.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  valid with `done`; misaligned address or reserved size.
- `rdata`  output  32  extended load result; holds until the next load completes.
- `mem_req`  output  1  byte transaction request.
- `mem_we`  output  1  write qualifier; valid while `mem_req` is high.
- `mem_addr`  output  ADDR_W  byte address.
- `mem_wdata`  output  8  write byte.
- `mem_ack`  input  1  responder accepts the byte this cycle; for reads, `mem_rdata` is valid this cycle.
- `mem_rdata`  input  8  read byte.

Behaviour:
- Reset (asynchronous, `RST`=0): state IDLE. `busy`, `done`, `err`, `mem_req`, `mem_we` = 0. `rdata`, `mem_addr`, `mem_wdata` = 0. Byte counter = 0.
- Reset asserted mid-transfer aborts it immediately; no `done` is produced. Memory contents already written stay written.
- States:
  - IDLE: on `start` with a legal request → ACCESS. Latch `addr`, `size`, `is_store`, `is_unsigned`, `wdata`; set counter N-1, where N = 1/2/4 for byte/half/word.
  - IDLE: on `start` with an illegal request → ERR. Illegal means half with `addr[0]`≠0, word with `addr[1:0]`≠0, or `size`=11.
  - ACCESS: `mem_req`=1, `mem_we`=`is_store`, `mem_addr` = base + (N-1-counter).
  - ACCESS, store byte: `mem_wdata` = latched data byte selected MSB-first from the low N bytes. For word, byte 0 = `wdata[31:24]`; for half, byte 0 = `wdata[15:8]`; for byte, `wdata[7:0]`.
  - ACCESS: signals are held unchanged until `mem_ack`=1. On `mem_ack`, loads shift the accumulator: acc = {acc[23:0], `mem_rdata`}.
  - ACCESS: on `mem_ack` with counter=0 → RESP; otherwise decrement the counter and step to the next byte.
  - RESP: `done`=1, `err`=0. On loads, `rdata` is updated the same cycle from acc[7:0] (byte) or acc[15:0] (half), extended per `is_unsigned`; word uses acc directly. Stores leave `rdata` unchanged. → IDLE.
  - ERR: `done`=1, `err`=1, no memory transaction, `rdata` unchanged → IDLE.
- Latency with `mem_ack` tied high: `start` in cycle 0; word bytes in cycles 1–4; `done` in cycle 5. Byte load: `done` in cycle 2. Each stall cycle (`mem_ack`=0) adds one cycle.
- `busy` = (state ≠ IDLE). `start` while busy is ignored, with no queuing.
- `mem_req` never drops between bytes of a multi-byte access with continuous ack. It is 0 in IDLE, RESP and ERR.
- `mem_ack` outside ACCESS is ignored.
- Address arithmetic is ADDR_W-bit modulo. A byte access at all-ones is legal, and there is no wrap in a legal multi-byte access because of alignment.
- `start` in the same cycle as `done` is not accepted; it must be re-presented in IDLE.

Decomposition:
- Shared package `lsu_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`/`SZ_RSVD`;
  - state enum IDLE/ACCESS/RESP/ERR;
  - function `bytes_for_size`;
  - function `extend_load(acc, size, unsigned)`.
- One natural sub-module: `lsu_load_extend`, a combinational extension and selection of the final `rdata` value. The FSM, counter and assembly stay in the top module.

Test Plan:
- Word store 0xDEADBEEF at addr 0x10, ack always high → `mem_addr` 0x10..0x13 with `mem_wdata` DE,AD,BE,EF in cycles 1–4; `done` in cycle 5, `err`=0, `rdata` unchanged.
- Word load from addr 0x10 after the store, with an ack stall of 2 cycles on byte 2 → `mem_addr` held at 0x12 for 3 cycles; `done` in cycle 7; `rdata`=0xDEADBEEF.
- Byte load at 0x11 (value 0xAD): signed → `rdata`=0xFFFFFFAD; unsigned → 0x000000AD. Half load at 0x12 signed → 0xFFFFBEEF.
- Half store at 0x13 → `done`+`err` in cycle 1, no `mem_req` ever. Word at 0x12 and `size`=11 give the same error behaviour.
- Word load in progress, `RST` low after byte 1 → `mem_req`, `busy`, `rdata` = 0 immediately; no `done` pulse after release. A following byte load succeeds.
- `start` pulsed while busy and in the RESP cycle → ignored; exactly one `done` per accepted request.
